// File: rtl/input_ram_ctrl.sv
// Drives port A of the input-sample RAM: captures one frame of samples, then lends the port to the FFT engine.
// RAM-side outputs are registered (one cycle after the causing input); there is no backpressure, samples outside FILL are dropped.
module input_ram_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 18,
    parameter int BIT_REV = 1
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              start,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              fft_go,
    input  logic              fft_done,
    input  logic [ADDR_W-1:0] fft_addr,
    input  logic [DATA_W-1:0] fft_din,
    input  logic              fft_we,
    output logic [ADDR_W-1:0] ram_addrA,
    output logic [DATA_W-1:0] ram_DinA,
    output logic              ram_weA,
    output logic              frame_ready,
    output logic              busy,
    output logic              overrun,
    output logic [ADDR_W:0]   sample_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] READY = 2'd2;
    localparam logic [1:0] BUSY  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] wr_addr;

    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        r = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = a[ADDR_W-1-i];
        end
        return r;
    endfunction

    assign wr_addr      = (BIT_REV != 0) ? bitrev(count[ADDR_W-1:0]) : count[ADDR_W-1:0];
    assign frame_ready  = (state == READY);
    assign busy         = (state == FILL) || (state == BUSY);
    assign sample_count = count;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            overrun   <= 1'b0;
            ram_addrA <= '0;
            ram_DinA  <= '0;
            ram_weA   <= 1'b0;
        end else begin
            ram_weA <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= FILL;
                        count   <= '0;
                        overrun <= 1'b0;
                    end
                end
                FILL: begin
                    // A restart drops any sample arriving in the same cycle.
                    if (start) begin
                        count   <= '0;
                        overrun <= 1'b0;
                    end else if (sample_valid) begin
                        ram_addrA <= wr_addr;
                        ram_DinA  <= sample_data;
                        ram_weA   <= 1'b1;
                        count     <= count + (ADDR_W+1)'(1);
                        if (count[ADDR_W-1:0] == '1) begin
                            state <= READY;
                        end
                    end
                end
                READY: begin
                    if (sample_valid) begin
                        overrun <= 1'b1;
                    end
                    if (fft_go) begin
                        state <= BUSY;
                    end else if (start) begin
                        state   <= FILL;
                        count   <= '0;
                        overrun <= 1'b0;
                    end
                end
                BUSY: begin
                    ram_addrA <= fft_addr;
                    ram_DinA  <= fft_din;
                    ram_weA   <= fft_we & ~fft_done;
                    if (sample_valid) begin
                        overrun <= 1'b1;
                    end
                    if (fft_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_input_ram_ctrl.sv
// Directed bench for input_ram_ctrl: expected RAM writes are queued at drive time and popped by a monitor.
module tb_input_ram_ctrl;
    localparam int AW = 10;
    localparam int DW = 18;
    localparam int N  = 1 << AW;

    logic          Clk = 1'b0;
    logic          reset, rst_nr;
    logic          start, start_nr, sample_valid, fft_go, fft_done, fft_we;
    logic [DW-1:0] sample_data, fft_din;
    logic [AW-1:0] fft_addr;

    logic [AW-1:0] ram_addrA, nr_addrA;
    logic [DW-1:0] ram_DinA, nr_DinA;
    logic          ram_weA, nr_weA, frame_ready, nr_ready, busy, nr_busy, overrun, nr_overrun;
    logic [AW:0]   sample_count, nr_count;

    logic [AW+DW-1:0] q[$];
    logic [AW+DW-1:0] q_nr[$];
    logic [AW+DW-1:0] tmp;
    int checks = 0;
    int fails  = 0;

    always #5 Clk = ~Clk;

    input_ram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .BIT_REV(1)) dut (
        .Clk(Clk), .reset(reset), .start(start), .sample_valid(sample_valid),
        .sample_data(sample_data), .fft_go(fft_go), .fft_done(fft_done),
        .fft_addr(fft_addr), .fft_din(fft_din), .fft_we(fft_we),
        .ram_addrA(ram_addrA), .ram_DinA(ram_DinA), .ram_weA(ram_weA),
        .frame_ready(frame_ready), .busy(busy), .overrun(overrun),
        .sample_count(sample_count)
    );

    input_ram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .BIT_REV(0)) dut_nr (
        .Clk(Clk), .reset(rst_nr), .start(start_nr), .sample_valid(sample_valid),
        .sample_data(sample_data), .fft_go(fft_go), .fft_done(fft_done),
        .fft_addr(fft_addr), .fft_din(fft_din), .fft_we(fft_we),
        .ram_addrA(nr_addrA), .ram_DinA(nr_DinA), .ram_weA(nr_weA),
        .frame_ready(nr_ready), .busy(nr_busy), .overrun(nr_overrun),
        .sample_count(nr_count)
    );

    function automatic logic [AW-1:0] rev(input int v);
        logic [AW-1:0] a;
        logic [AW-1:0] r;
        a = AW'(v);
        r = '0;
        for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Drive n samples in FILL; data = base + index; checks frame_ready only when a full frame is sent.
    task automatic fill(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            if (n == N && i == N - 1) chk("ready_before_last", {31'd0, frame_ready}, 32'd0);
            sample_valid = 1'b1;
            sample_data  = DW'(base + i);
            q.push_back({rev(i), DW'(base + i)});
            tick();
        end
        sample_valid = 1'b0;
        if (n == N) begin
            chk("ready_after_last", {31'd0, frame_ready}, 32'd1);
            chk("count_full", 32'(sample_count), N);
        end
    endtask

    always @(negedge Clk) begin
        if (ram_weA === 1'b1) begin
            checks++;
            assert (q.size() != 0) else begin
                fails++;
                $error("FAIL wr_unexpected: got addr %0d data %0d expected no write", ram_addrA, ram_DinA);
            end
            if (q.size() != 0) begin
                tmp = q.pop_front();
                checks++;
                assert ({ram_addrA, ram_DinA} === tmp) else begin
                    fails++;
                    $error("FAIL wr_addr_data: got addr %0d data %0d expected addr %0d data %0d",
                           ram_addrA, ram_DinA, tmp[AW+DW-1:DW], tmp[DW-1:0]);
                end
            end
        end
        if (nr_weA === 1'b1) begin
            checks++;
            assert (q_nr.size() != 0) else begin
                fails++;
                $error("FAIL nr_wr_unexpected: got addr %0d data %0d expected no write", nr_addrA, nr_DinA);
            end
            if (q_nr.size() != 0) begin
                tmp = q_nr.pop_front();
                checks++;
                assert ({nr_addrA, nr_DinA} === tmp) else begin
                    fails++;
                    $error("FAIL nr_wr_addr_data: got addr %0d data %0d expected addr %0d data %0d",
                           nr_addrA, nr_DinA, tmp[AW+DW-1:DW], tmp[DW-1:0]);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; rst_nr = 1'b1; start = 1'b0; start_nr = 1'b0;
        sample_valid = 1'b0; sample_data = '0; fft_go = 1'b0; fft_done = 1'b0;
        fft_addr = '0; fft_din = '0; fft_we = 1'b0;
        tick(); tick();
        chk("rst_addr", 32'(ram_addrA), 32'd0);
        chk("rst_din", 32'(ram_DinA), 32'd0);
        chk("rst_we", {31'd0, ram_weA}, 32'd0);
        chk("rst_ready", {31'd0, frame_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_count", 32'(sample_count), 32'd0);
        reset = 1'b0; rst_nr = 1'b0;
        tick();

        // Samples in IDLE are ignored and do not flag overrun.
        sample_valid = 1'b1; sample_data = 18'd77;
        tick();
        sample_valid = 1'b0;
        tick();
        chk("idle_overrun", {31'd0, overrun}, 32'd0);
        chk("idle_count", 32'(sample_count), 32'd0);

        // Full bit-reversed frame, data = index.
        start = 1'b1; tick(); start = 1'b0;
        chk("fill_busy", {31'd0, busy}, 32'd1);
        fill(N, 0);

        // Sample in READY: overrun, no write; start clears it and re-enters FILL.
        sample_valid = 1'b1; sample_data = 18'd99;
        tick();
        sample_valid = 1'b0;
        chk("ready_overrun", {31'd0, overrun}, 32'd1);
        chk("ready_still", {31'd0, frame_ready}, 32'd1);
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_overrun", {31'd0, overrun}, 32'd0);
        chk("restart_fill", {31'd0, busy}, 32'd1);
        chk("restart_notready", {31'd0, frame_ready}, 32'd0);

        // Partial capture, then restart with a coincident sample that must be dropped.
        fill(10, 2000);
        chk("partial_count", 32'(sample_count), 32'd10);
        start = 1'b1; sample_valid = 1'b1; sample_data = 18'd555;
        tick();
        start = 1'b0; sample_valid = 1'b0;
        chk("restart_count", 32'(sample_count), 32'd0);
        fill(N, 1000);

        // FFT engine owns port A.
        fft_go = 1'b1; tick(); fft_go = 1'b0;
        chk("go_busy", {31'd0, busy}, 32'd1);
        chk("go_notready", {31'd0, frame_ready}, 32'd0);
        fft_addr = 10'd1020; fft_din = 18'd3; fft_we = 1'b1;
        q.push_back({10'd1020, 18'd3});
        tick();
        fft_we = 1'b0; fft_din = 18'd0;
        tick();
        chk("fft_rd_addr", 32'(ram_addrA), 32'd1020);
        chk("fft_rd_we", {31'd0, ram_weA}, 32'd0);
        fft_done = 1'b1; fft_we = 1'b1; fft_din = 18'd9; start = 1'b1;
        tick();
        fft_done = 1'b0; fft_we = 1'b0; start = 1'b0;
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_ready", {31'd0, frame_ready}, 32'd0);
        chk("done_we", {31'd0, ram_weA}, 32'd0);
        chk("done_count", 32'(sample_count), N);
        tick();

        // Natural-order instance; the main instance is IDLE and ignores these samples.
        start_nr = 1'b1; tick(); start_nr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample_valid = 1'b1;
            sample_data  = DW'(5 + i);
            q_nr.push_back({AW'(i), DW'(5 + i)});
            tick();
        end
        sample_valid = 1'b0;
        chk("nr_count", 32'(nr_count), 32'd3);
        chk("nr_last_addr", 32'(nr_addrA), 32'd2);
        chk("main_idle_overrun", {31'd0, overrun}, 32'd0);
        tick();
        rst_nr = 1'b1; tick(); rst_nr = 1'b0;

        // Reset in the middle of a fill suppresses the in-flight write.
        start = 1'b1; tick(); start = 1'b0;
        fill(500, 300);
        #1 reset = 1'b1;
        #1;
        tmp = q.pop_back();
        chk("mid_rst_we", {31'd0, ram_weA}, 32'd0);
        chk("mid_rst_addr", 32'(ram_addrA), 32'd0);
        chk("mid_rst_din", 32'(ram_DinA), 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_count", 32'(sample_count), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        chk("post_rst_count", 32'(sample_count), 32'd0);
        fill(N, 7);

        // fft_go wins over start; start is then ignored in BUSY.
        fft_go = 1'b1; start = 1'b1;
        tick();
        chk("coll1_busy", {31'd0, busy}, 32'd1);
        chk("coll1_ready", {31'd0, frame_ready}, 32'd0);
        tick();
        fft_go = 1'b0; start = 1'b0;
        chk("coll2_busy", {31'd0, busy}, 32'd1);
        chk("coll2_count", 32'(sample_count), N);
        fft_done = 1'b1; tick(); fft_done = 1'b0;
        chk("coll_done_busy", {31'd0, busy}, 32'd0);

        tick(); tick();
        chk("q_empty", 32'(q.size()), 32'd0);
        chk("q_nr_empty", 32'(q_nr.size()), 32'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
